// File: rtl/atm_core_v2.sv
// atm_core_v2: ATM session controller with a provisioned account store,
// wrong-password lockout, per-session withdrawal cap and idle timeout.
module atm_core_v2 #(
    parameter int PASSWORD_WIDTH = 4,
    parameter int BALANCE_WIDTH  = 20,
    parameter int CARD_WIDTH     = 3,
    parameter int USERS_NUM      = 7,
    parameter int MAX_TRIES      = 3,
    parameter int SESSION_LIMIT  = 5000,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CARD_WIDTH-1:0]     card_number,
    input  logic                      card_out,
    input  logic [PASSWORD_WIDTH-1:0] password_input,
    input  logic                      language,
    input  logic [1:0]                operation,
    input  logic [BALANCE_WIDTH-1:0]  value,
    input  logic                      another_service,
    input  logic                      prog_en,
    input  logic [CARD_WIDTH-1:0]     prog_card,
    input  logic [PASSWORD_WIDTH-1:0] prog_password,
    input  logic [BALANCE_WIDTH-1:0]  prog_balance,
    output logic [BALANCE_WIDTH-1:0]  updated_balance,
    output logic                      op_done,
    output logic                      error,
    output logic                      wrong_psw,
    output logic                      card_locked,
    output logic                      timeout,
    output logic                      busy,
    output logic                      lang_sel
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CHECK = 3'd1;
    localparam logic [2:0] MENU  = 3'd2;
    localparam logic [2:0] EXEC  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam int TW  = $clog2(MAX_TRIES + 1);
    localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);

    logic [BALANCE_WIDTH-1:0]  bal_mem   [USERS_NUM];
    logic [PASSWORD_WIDTH-1:0] psw_mem   [USERS_NUM];
    logic [TW-1:0]             tries_mem [USERS_NUM];
    logic [USERS_NUM-1:0]      lock_mem;

    logic [2:0]               state, state_nxt;
    logic [CARD_WIDTH-1:0]    card;
    logic [1:0]               op;
    logic [BALANCE_WIDTH-1:0] val, session_total, res_bal, cur_bal, exec_bal;
    logic [BALANCE_WIDTH:0]   sum, wd_total;
    logic [TMW-1:0]           timer;
    logic [TW-1:0]            tries_nxt;
    logic res_ok, exec_err, card_valid, prog_valid, psw_ok, lock_now, timer_hit;
    logic idle_ins, chk, in_wait;

    assign card_valid = 32'(card_number) < USERS_NUM;
    assign prog_valid = 32'(prog_card) < USERS_NUM;
    assign cur_bal    = bal_mem[card];
    assign sum        = {1'b0, cur_bal} + {1'b0, val};
    assign wd_total   = {1'b0, session_total} + {1'b0, val};
    assign exec_err   = (op == 2'b00) ? sum[BALANCE_WIDTH] :
                        (op == 2'b01) ? (val > cur_bal || wd_total > (BALANCE_WIDTH+1)'(SESSION_LIMIT)) : 1'b0;
    assign exec_bal   = (op == 2'b00) ? sum[BALANCE_WIDTH-1:0] :
                        (op == 2'b01) ? cur_bal - val : cur_bal;
    assign psw_ok     = password_input == psw_mem[card];
    assign tries_nxt  = tries_mem[card] + TW'(1);
    assign lock_now   = tries_nxt == TW'(MAX_TRIES);
    assign timer_hit  = timer == TMW'(TIMEOUT_CYCLES - 1);
    assign in_wait    = state == CHECK || state == MENU;
    assign idle_ins   = state == IDLE && !prog_en && !card_out;
    assign chk        = state == CHECK && !card_out && !timer_hit;

    // Card removal overrides every other transition out of a non-IDLE state.
    always_comb begin
        state_nxt = state;
        if (state != IDLE && card_out)
            state_nxt = IDLE;
        else
            case (state)
                IDLE:    state_nxt = (idle_ins && card_valid && !lock_mem[card_number]) ? CHECK : IDLE;
                CHECK:   state_nxt = timer_hit ? IDLE : psw_ok ? MENU : lock_now ? IDLE : CHECK;
                MENU:    state_nxt = timer_hit ? IDLE : EXEC;
                EXEC:    state_nxt = DONE;
                DONE:    state_nxt = another_service ? MENU : IDLE;
                default: state_nxt = IDLE;
            endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            card            <= '0;
            op              <= '0;
            val             <= '0;
            session_total   <= '0;
            timer           <= '0;
            res_ok          <= 1'b0;
            res_bal         <= '0;
            updated_balance <= '0;
            op_done         <= 1'b0;
            error           <= 1'b0;
            wrong_psw       <= 1'b0;
            card_locked     <= 1'b0;
            timeout         <= 1'b0;
            busy            <= 1'b0;
            lang_sel        <= 1'b0;
            lock_mem        <= '0;
            for (int i = 0; i < USERS_NUM; i++) begin
                bal_mem[i]   <= '0;
                psw_mem[i]   <= '0;
                tries_mem[i] <= '0;
            end
        end else begin
            state       <= state_nxt;
            busy        <= state_nxt != IDLE;
            timer       <= (state == IDLE || state_nxt != state) ? '0 : timer + TMW'(1);
            op_done     <= state == DONE && res_ok;
            error       <= (idle_ins && !card_valid) || (state == DONE && !res_ok);
            wrong_psw   <= chk && !psw_ok;
            card_locked <= (idle_ins && card_valid && lock_mem[card_number]) || (chk && !psw_ok && lock_now);
            timeout     <= in_wait && !card_out && timer_hit;
            // The result of a committed op is reported from DONE even if the card leaves then.
            if (state == DONE && res_ok)
                updated_balance <= res_bal;
            if (state == IDLE && prog_en && prog_valid) begin
                psw_mem[prog_card]   <= prog_password;
                bal_mem[prog_card]   <= prog_balance;
                tries_mem[prog_card] <= '0;
                lock_mem[prog_card]  <= 1'b0;
            end
            if (state == IDLE && state_nxt == CHECK) begin
                card          <= card_number;
                session_total <= '0;
            end
            if (chk) begin
                tries_mem[card] <= psw_ok ? '0 : tries_nxt;
                if (!psw_ok && lock_now)
                    lock_mem[card] <= 1'b1;
            end
            if (state == MENU && !card_out && !timer_hit) begin
                op       <= operation;
                val      <= value;
                lang_sel <= language;
            end
            if (state == EXEC && !card_out) begin
                res_ok  <= !exec_err;
                res_bal <= exec_bal;
                if (!exec_err) begin
                    bal_mem[card] <= exec_bal;
                    if (op == 2'b01)
                        session_total <= wd_total[BALANCE_WIDTH-1:0];
                    if (op == 2'b11)
                        psw_mem[card] <= val[PASSWORD_WIDTH-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_atm_core_v2.sv
// tb_atm_core_v2: scoreboard bench for atm_core_v2 driven by directed and random
// sessions against an account-level reference model.
module tb_atm_core_v2;
    localparam int U     = 7;
    localparam int MAXT  = 3;
    localparam int LIMIT = 5000;

    logic        clk = 0;
    logic        rst = 1;
    logic [2:0]  card_number = 0;
    logic        card_out = 1;
    logic        card_out2 = 1;
    logic [3:0]  password_input = 0;
    logic        language = 0;
    logic [1:0]  operation = 0;
    logic [19:0] value = 0;
    logic        another_service = 0;
    logic        prog_en = 0;
    logic [2:0]  prog_card = 0;
    logic [3:0]  prog_password = 0;
    logic [19:0] prog_balance = 0;
    logic [19:0] updated_balance, u2_bal;
    logic op_done, error, wrong_psw, card_locked, timeout, busy, lang_sel;
    logic u2_done, u2_err, u2_wrong, u2_locked, u2_to, u2_busy, u2_lang;

    atm_core_v2 dut (
        .clk(clk), .rst(rst), .card_number(card_number), .card_out(card_out),
        .password_input(password_input), .language(language), .operation(operation),
        .value(value), .another_service(another_service), .prog_en(prog_en),
        .prog_card(prog_card), .prog_password(prog_password), .prog_balance(prog_balance),
        .updated_balance(updated_balance), .op_done(op_done), .error(error),
        .wrong_psw(wrong_psw), .card_locked(card_locked), .timeout(timeout),
        .busy(busy), .lang_sel(lang_sel)
    );

    // Lockout pushed out of reach so a persistent mismatch runs into the idle timeout.
    atm_core_v2 #(.MAX_TRIES(100), .TIMEOUT_CYCLES(8)) dut2 (
        .clk(clk), .rst(rst), .card_number(card_number), .card_out(card_out2),
        .password_input(password_input), .language(language), .operation(operation),
        .value(value), .another_service(another_service), .prog_en(1'b0),
        .prog_card(prog_card), .prog_password(prog_password), .prog_balance(prog_balance),
        .updated_balance(u2_bal), .op_done(u2_done), .error(u2_err),
        .wrong_psw(u2_wrong), .card_locked(u2_locked), .timeout(u2_to),
        .busy(u2_busy), .lang_sel(u2_lang)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  flags;
        logic [19:0] ub;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int fails = 0;
    int cyc = 0;

    int          m_bal[8];
    logic [3:0]  m_pw[8];
    int          m_tries[8];
    bit          m_lock[8];
    logic [19:0] m_ub = 0;
    logic [1:0]  ops[4];
    logic [19:0] vals[4];

    function automatic void push(int c, bit od, bit er, bit wp, bit cl, bit to);
        exp_t e;
        e.cyc = c;
        e.flags = {od, er, wp, cl, to};
        e.ub = m_ub;
        sbq.push_back(e);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        logic [4:0] got;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            got = {op_done, error, wrong_psw, card_locked, timeout};
            if (got != 5'b0) begin
                checks++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse cyc=%0d flags=%b ub=%0d", cyc, got, updated_balance);
                end else begin
                    e = sbq.pop_front();
                    if (cyc != e.cyc || got != e.flags || updated_balance != e.ub) begin
                        fails++;
                        $display("FAIL pulse cyc=%0d/%0d flags=%b/%b ub=%0d/%0d (got/expected)",
                                 cyc, e.cyc, got, e.flags, updated_balance, e.ub);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic provision(input int c, input int p, input int b);
        @(negedge clk);
        prog_en = 1;
        prog_card = 3'(c);
        prog_password = 4'(p);
        prog_balance = 20'(b);
        @(negedge clk);
        prog_en = 0;
        if (c < U) begin
            m_pw[c] = 4'(p);
            m_bal[c] = b;
            m_tries[c] = 0;
            m_lock[c] = 0;
        end
    endtask

    task automatic session(input int c, input int p, input int n, input bit ab);
        int n0, st, v, k;
        bit lng, ok;
        @(negedge clk);
        lng = 1'($urandom);
        card_number = 3'(c);
        password_input = 4'(p);
        card_out = 0;
        operation = ops[0];
        value = vals[0];
        another_service = n > 1;
        language = lng;
        n0 = cyc;
        if (c >= U || m_lock[c]) begin
            if (c >= U) push(n0 + 1, 0, 1, 0, 0, 0);
            else        push(n0 + 1, 0, 0, 0, 1, 0);
            @(negedge clk);
            card_out = 1;
            check("busy_reject", busy, 0);
            return;
        end
        if (4'(p) != m_pw[c]) begin
            k = 0;
            do begin
                m_tries[c]++;
                k++;
                push(n0 + 1 + k, 0, 0, 1, m_tries[c] == MAXT, 0);
            end while (m_tries[c] < MAXT);
            m_lock[c] = 1;
            repeat (k + 1) @(negedge clk);
            card_out = 1;
            check("busy_locked", busy, 0);
            return;
        end
        m_tries[c] = 0;
        st = 0;
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("busy_menu", busy, 1);
            operation = ops[i];
            value = vals[i];
            another_service = i < n - 1;
            if (ab && i == n - 1) begin
                @(posedge clk);
                @(negedge clk);
                card_out = 1;
                @(negedge clk);
                check("busy_abort", busy, 0);
                return;
            end
            repeat (3) @(posedge clk);
            v = int'(vals[i]);
            ok = 1;
            case (ops[i])
                2'd0: if (m_bal[c] + v > 20'hFFFFF) ok = 0; else m_bal[c] += v;
                2'd1: if (v > m_bal[c] || st + v > LIMIT) ok = 0;
                      else begin m_bal[c] -= v; st += v; end
                2'd3: m_pw[c] = 4'(v % 16);
                default: ;
            endcase
            if (ok) m_ub = 20'(m_bal[c]);
            push(n0 + 5 + 3 * i, ok, !ok, 0, 0, 0);
        end
        @(negedge clk);
        card_out = 1;
        check("busy_end", busy, 0);
        check("lang_sel", lang_sel, lng);
    endtask

    function automatic void set_op(int i, int o, int v);
        ops[i] = 2'(o);
        vals[i] = 20'(v);
    endfunction

    initial begin
        int wp2, to2, toe, c, p, n;
        for (int i = 0; i < 8; i++) begin
            m_bal[i] = 0; m_pw[i] = 0; m_tries[i] = 0; m_lock[i] = 0;
        end
        #1 rst = 0;
        repeat (2) @(negedge clk);
        check("reset_state", {updated_balance, op_done, error, wrong_psw, card_locked, timeout, busy, lang_sel}, 0);
        rst = 1;

        provision(2, 5, 1000);
        set_op(0, 2, 0);
        session(2, 5, 1, 0);
        set_op(0, 1, 300); set_op(1, 1, 4800);
        session(2, 5, 2, 0);
        provision(3, 7, 9000);
        set_op(0, 1, 3000); set_op(1, 1, 2500);
        session(3, 7, 2, 0);

        set_op(0, 2, 0);
        session(2, 15, 1, 0);
        session(2, 5, 1, 0);
        provision(2, 5, 700);
        session(7, 5, 1, 0);
        provision(4, 3, 20'hFFFFF - 9);
        set_op(0, 0, 20);
        session(4, 3, 1, 0);

        set_op(0, 3, 9);
        session(2, 5, 1, 0);
        set_op(0, 2, 0);
        session(2, 9, 1, 0);
        session(2, 5, 1, 0);
        provision(2, 9, 700);

        wp2 = 0; to2 = 0; toe = 0;
        @(negedge clk);
        card_number = 0;
        password_input = 5;
        card_out2 = 0;
        for (int j = 1; j <= 9; j++) begin
            @(posedge clk);
            #2;
            wp2 += int'(u2_wrong);
            if (u2_to) begin to2++; toe = j; end
        end
        @(negedge clk);
        card_out2 = 1;
        check("timeout_wrong_count", wp2, 7);
        check("timeout_pulses", to2, 1);
        check("timeout_edge", toe, 9);
        check("timeout_busy", u2_busy, 0);

        set_op(0, 0, 50);
        session(2, 9, 1, 1);
        set_op(0, 2, 0);
        session(2, 9, 1, 0);

        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                provision($urandom_range(0, 7), $urandom_range(0, 15),
                          $urandom_range(0, 1) ? $urandom_range(0, 20000) : $urandom_range(20'hFFF00, 20'hFFFFF));
            end else begin
                c = $urandom_range(0, 7);
                p = (c < U && $urandom_range(0, 3) != 0) ? int'(m_pw[c]) : $urandom_range(0, 15);
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) begin
                    ops[i] = 2'($urandom_range(0, 3));
                    vals[i] = (ops[i] == 2'd1) ? 20'($urandom_range(0, 6000)) :
                              (ops[i] == 2'd0 && $urandom_range(0, 1)) ? 20'($urandom) : 20'($urandom_range(0, 3000));
                end
                session(c, p, n, $urandom_range(0, 7) == 0);
            end
        end

        provision(2, 6, 1234);
        @(negedge clk);
        card_number = 2;
        password_input = 6;
        operation = 1;
        value = 100;
        another_service = 0;
        card_out = 0;
        repeat (3) @(posedge clk);
        #3 rst = 0;
        #1 check("reset_mid_exec", {updated_balance, op_done, error, wrong_psw, card_locked, timeout, busy, lang_sel}, 0);
        card_out = 1;
        for (int i = 0; i < 8; i++) begin
            m_bal[i] = 0; m_pw[i] = 0; m_tries[i] = 0; m_lock[i] = 0;
        end
        m_ub = 0;
        @(negedge clk);
        rst = 1;
        set_op(0, 2, 0);
        session(2, 0, 1, 0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
